intc_pend: RTL and testbench

Pending/arbitration front end of the interrupt controller, placed directly upstream of the priority encoder `pr_enc`. It edge-detects the accelerator done lines and latches each event as pending. It then presents exactly one unmasked pending source at a time on the encoder's `done[3:0]` input and holds it until the CPU signals end-of-interrupt. It also records sticky overrun flags for events that arrive while the same source is still pending.

---
 rtl/intc_pend.sv | 128 ++++++++++++
 tb/tb_intc_pend.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/intc_pend.sv
// intc_pend: pending/arbitration front end for the pr_enc priority encoder.
// Edge-detects accelerator done lines, latches pending events, and presents
// one unmasked pending source at a time until end-of-interrupt.
module intc_pend #(
    parameter int N_SRC = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SRC-1:0]           acc_done,
    input  logic [N_SRC-1:0]           irq_mask,
    input  logic                       eoi,
    input  logic [N_SRC-1:0]           ovr_clr,
    output logic [N_SRC-1:0]           done,
    output logic                       isr_busy,
    output logic [$clog2(N_SRC)-1:0]   isr_id,
    output logic [N_SRC-1:0]           pending,
    output logic [N_SRC-1:0]           overrun
);
    localparam int IW = $clog2(N_SRC);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_SERVICE = 2'b01,
        S_GAP     = 2'b10
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [N_SRC-1:0]  r_acc_q;
    logic [N_SRC-1:0]  r_pending;
    logic [N_SRC-1:0]  r_overrun;
    logic [N_SRC-1:0]  r_done, w_done_nxt;
    logic              r_busy, w_busy_nxt;
    logic [IW-1:0]     r_isr_id, w_isr_id_nxt;

    logic [N_SRC-1:0]  w_rise;
    logic [N_SRC-1:0]  w_clr;
    logic [N_SRC-1:0]  w_cand;
    logic [IW-1:0]     w_sel;
    logic [N_SRC-1:0]  w_one;

    assign w_rise = acc_done & ~r_acc_q;
    assign w_cand = r_pending & irq_mask;
    assign w_one  = {{(N_SRC-1){1'b0}}, 1'b1};

    // Only the in-service source can be retired, and only by eoi in SERVICE.
    assign w_clr = (r_state == S_SERVICE && eoi) ? (w_one << r_isr_id) : '0;

    // Lowest set index wins (source 0 highest priority, as in pr_enc).
    always_comb begin
        w_sel = '0;
        for (int i = N_SRC-1; i >= 0; i--) begin
            if (w_cand[i]) w_sel = IW'(i);
        end
    end

    // Edge-detect register plus pending/overrun bookkeeping; set beats clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc_q   <= '0;
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_acc_q   <= acc_done;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_overrun <= (r_overrun & ~ovr_clr) | (w_rise & r_pending & ~w_clr);
        end
    end

    // FSM state and registered presentation outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_done   <= '0;
            r_busy   <= 1'b0;
            r_isr_id <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
            r_isr_id <= w_isr_id_nxt;
        end
    end

    // Next-state and next-output decode; no pre-emption while in SERVICE.
    always_comb begin
        w_state_nxt  = r_state;
        w_done_nxt   = r_done;
        w_busy_nxt   = r_busy;
        w_isr_id_nxt = r_isr_id;
        case (r_state)
            S_IDLE: begin
                w_done_nxt = '0;
                w_busy_nxt = 1'b0;
                if (w_cand != '0) begin
                    w_state_nxt  = S_SERVICE;
                    w_isr_id_nxt = w_sel;
                    w_done_nxt   = w_one << w_sel;
                    w_busy_nxt   = 1'b1;
                end
            end
            S_SERVICE: begin
                if (eoi) begin
                    w_state_nxt = S_GAP;
                    w_done_nxt  = '0;
                    w_busy_nxt  = 1'b0;
                end
            end
            S_GAP: begin
                // One dead cycle so pr_enc drops irq between services.
                w_state_nxt = S_IDLE;
                w_done_nxt  = '0;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign done     = r_done;
    assign isr_busy = r_busy;
    assign isr_id   = r_isr_id;
    assign pending  = r_pending;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_intc_pend.sv
// Directed bench for intc_pend with hand-computed expectations.
module tb_intc_pend;
    logic       clk;
    logic       rst;
    logic [3:0] acc_done;
    logic [3:0] irq_mask;
    logic       eoi;
    logic [3:0] ovr_clr;
    logic [3:0] done;
    logic       isr_busy;
    logic [1:0] isr_id;
    logic [3:0] pending;
    logic [3:0] overrun;

    int n_chk;
    int n_pass;

    intc_pend #(.N_SRC(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .acc_done (acc_done),
        .irq_mask (irq_mask),
        .eoi      (eoi),
        .ovr_clr  (ovr_clr),
        .done     (done),
        .isr_busy (isr_busy),
        .isr_id   (isr_id),
        .pending  (pending),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b0; acc_done = '0; irq_mask = 4'hF; eoi = 1'b0; ovr_clr = '0;
        repeat (3) step();
        chk("rst_done",    32'(done),     32'h0);
        chk("rst_busy",    32'(isr_busy), 32'h0);
        chk("rst_id",      32'(isr_id),   32'h0);
        chk("rst_pending", 32'(pending),  32'h0);
        chk("rst_overrun", 32'(overrun),  32'h0);
        rst = 1'b1;
        step();

        // Single pulse on source 2.
        acc_done = 4'b0100; step();
        chk("t1_pend",  32'(pending), 32'h4);
        chk("t1_done0", 32'(done),    32'h0);
        acc_done = '0; step();
        chk("t1_done",  32'(done),     32'h4);
        chk("t1_id",    32'(isr_id),   32'h2);
        chk("t1_busy",  32'(isr_busy), 32'h1);
        eoi = 1'b1; step(); eoi = 1'b0;
        chk("t1_eoi_done", 32'(done),     32'h0);
        chk("t1_eoi_busy", 32'(isr_busy), 32'h0);
        chk("t1_eoi_pend", 32'(pending),  32'h0);
        step(); step();
        chk("t1_idle", 32'(done), 32'h0);

        // Sources 1 and 3 together: 1 first, then one gap cycle, then 3.
        acc_done = 4'b1010; step();
        chk("t2_pend", 32'(pending), 32'hA);
        acc_done = '0; step();
        chk("t2_done1", 32'(done), 32'h2);
        eoi = 1'b1; step(); eoi = 1'b0;
        chk("t2_eoi_done", 32'(done),    32'h0);
        chk("t2_eoi_pend", 32'(pending), 32'h8);
        step();
        chk("t2_gap", 32'(done), 32'h0);
        step();
        chk("t2_done3", 32'(done),   32'h8);
        chk("t2_id3",   32'(isr_id), 32'h3);

        // Source 0 arrives during source 3 service: no pre-emption.
        acc_done = 4'b0001; step();
        chk("t3_pend", 32'(pending), 32'h9);
        chk("t3_hold", 32'(done),    32'h8);
        acc_done = '0; step();
        chk("t3_hold2", 32'(done), 32'h8);
        eoi = 1'b1; step(); eoi = 1'b0;
        step(); step();
        chk("t3_done0", 32'(done), 32'h1);
        eoi = 1'b1; step(); eoi = 1'b0;
        step(); step();

        // Masked source latches pending but is not presented.
        irq_mask = 4'b1110;
        acc_done = 4'b0001; step();
        chk("t4_pend", 32'(pending), 32'h1);
        acc_done = '0; step(); step();
        chk("t4_masked", 32'(done), 32'h0);
        irq_mask = 4'hF; step();
        chk("t4_unmask", 32'(done), 32'h1);
        eoi = 1'b1; step(); eoi = 1'b0;
        step(); step();

        // Overrun on source 1.
        acc_done = 4'b0010; step();
        acc_done = '0; step();
        chk("t5_done", 32'(done), 32'h2);
        acc_done = 4'b0010; step();
        chk("t5_ovr", 32'(overrun), 32'h2);
        acc_done = '0; eoi = 1'b1; step(); eoi = 1'b0;
        chk("t5_ovr_eoi",  32'(overrun), 32'h2);
        chk("t5_pend_eoi", 32'(pending), 32'h0);
        step(); step();
        ovr_clr = 4'b0010; step(); ovr_clr = '0;
        chk("t5_ovr_clr", 32'(overrun), 32'h0);

        // Rise coincident with the clearing eoi: set wins, no overrun.
        acc_done = 4'b0010; step();
        acc_done = '0; step();
        chk("t5b_done", 32'(done), 32'h2);
        acc_done = 4'b0010; eoi = 1'b1; step();
        acc_done = '0; eoi = 1'b0;
        chk("t5b_pend", 32'(pending), 32'h2);
        chk("t5b_ovr",  32'(overrun), 32'h0);
        chk("t5b_done0", 32'(done),   32'h0);
        step(); step();
        chk("t5b_again", 32'(done), 32'h2);

        // Asynchronous reset mid-service.
        #2 rst = 1'b0;
        #1;
        chk("t6_done", 32'(done),     32'h0);
        chk("t6_pend", 32'(pending),  32'h0);
        chk("t6_busy", 32'(isr_busy), 32'h0);
        acc_done = 4'b1000;
        step();
        rst = 1'b1;
        step();
        chk("t6_pend3", 32'(pending), 32'h8);
        chk("t6_done0", 32'(done),    32'h0);
        step();
        chk("t6_done3", 32'(done),   32'h8);
        chk("t6_id3",   32'(isr_id), 32'h3);

        // Held-high level gives no second event.
        eoi = 1'b1; step(); eoi = 1'b0;
        step(); step(); step();
        chk("t7_held_done", 32'(done),    32'h0);
        chk("t7_held_pend", 32'(pending), 32'h0);
        acc_done = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
